filtro_linea_infrarojo: RTL and testbench

- Sits directly downstream of the per-sensor infrared reflectance counters. It consumes the N hayNegro flags, one per sensor.
- Each flag is debounced on a slow sample tick. The block then encodes the line position and tracks line-present, line-lost and no-line states.
- Outputs position, status and a change strobe to the steering/NIOS register interface.

---
 rtl/filtro_linea_infrarojo_pkg.sv | 17 +
 rtl/filtro_linea_infrarojo_antirrebote.sv | 47 ++++
 rtl/filtro_linea_infrarojo.sv | 202 ++++++++++++++++++++
 tb/tb_filtro_linea_infrarojo.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/filtro_linea_infrarojo_pkg.sv
// -----------------------------------------------------------------------------
// paquete_infrarojo
// Shared constants for the infrared line filter: FSM state encoding and the
// encoding of the side on which the line was last lost.
// -----------------------------------------------------------------------------
package paquete_infrarojo;

  // Line tracking states
  localparam logic [1:0] SIN_LINEA = 2'd0;
  localparam logic [1:0] EN_LINEA  = 2'd1;
  localparam logic [1:0] PERDIDA   = 2'd2;

  // Side of the last loss
  localparam logic LADO_IZQ = 1'b0;
  localparam logic LADO_DER = 1'b1;

endpackage

// File: rtl/filtro_linea_infrarojo_antirrebote.sv
// -----------------------------------------------------------------------------
// antirrebote_canal
// Debounces one hayNegro channel on the sample tick. The filtered bit only
// follows the raw bit after DEBOUNCE consecutive ticks of disagreement; any
// agreeing tick restarts the count.
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous active-low reset
//   tick     in   sample strobe (one clock wide)
//   raw      in   registered raw flag
//   filtrado out  debounced flag
// -----------------------------------------------------------------------------
module antirrebote_canal
  import paquete_infrarojo::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic filtrado
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [CNT_W-1:0] cnt_r;

  // Disagreement counter and filtered bit, advanced only on sample ticks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r    <= '0;
      filtrado <= 1'b0;
    end else if (tick) begin
      if (raw == filtrado) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        filtrado <= raw;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/filtro_linea_infrarojo.sv
// -----------------------------------------------------------------------------
// filtro_linea_infrarojo
// Debounces the per-sensor hayNegro flags, encodes the line position as
// min_idx+max_idx of the active channels and tracks line presence
// (SIN_LINEA / EN_LINEA / PERDIDA).
// Optional feature: define FILTRO_LINEA_CONTADOR_EN to add the saturating
// loss counter output perdidasTotales.
// Ports:
//   clock           in   system clock
//   reset           in   asynchronous active-low reset
//   hayNegro        in   raw black flags, bit 0 = leftmost sensor
//   filtrado        out  debounced flags
//   posicion        out  min_idx+max_idx (0..2N-2, center N-1)
//   enLinea         out  state is EN_LINEA
//   perdida         out  state is PERDIDA
//   lado            out  side of last loss (0 left, 1 right)
//   cambio          out  one-cycle pulse on posicion or state change
//   perdidasTotales out  number of losses, saturating (optional)
// -----------------------------------------------------------------------------
module filtro_linea_infrarojo
  import paquete_infrarojo::*;
#(
  parameter int N_SENSORES = 4,
  parameter int SAMPLE_DIV = 50000,
  parameter int DEBOUNCE   = 3,
  parameter int LOST_HOLD  = 100
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_SENSORES-1:0]           hayNegro,
  output logic [N_SENSORES-1:0]           filtrado,
  output logic [$clog2(2*N_SENSORES)-1:0] posicion,
  output logic                            enLinea,
  output logic                            perdida,
  output logic                            lado,
  output logic                            cambio
`ifdef FILTRO_LINEA_CONTADOR_EN
  ,output logic [15:0]                    perdidasTotales
`endif
);

  localparam int POS_W  = $clog2(2*N_SENSORES);
  localparam int PRE_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HOLD_W = (LOST_HOLD > 1) ? $clog2(LOST_HOLD) : 1;
  localparam logic [POS_W-1:0]  POS_CENTRO = POS_W'(N_SENSORES - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(LOST_HOLD - 1);

  logic [N_SENSORES-1:0] raw_r;
  logic [PRE_W-1:0]      pre_r;
  logic                  tick_s;
  logic [1:0]            state_r;
  logic [1:0]            state_next_s;
  logic [HOLD_W-1:0]     hold_r;
  logic [HOLD_W-1:0]     hold_next_s;
  logic [POS_W-1:0]      min_idx_s;
  logic [POS_W-1:0]      max_idx_s;
  logic [POS_W-1:0]      pos_calc_s;
  logic [POS_W-1:0]      pos_next_s;
  logic                  hay_linea_s;
  logic                  se_pierde_s;

  // Input register for the raw flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      raw_r <= '0;
    end else begin
      raw_r <= hayNegro;
    end
  end

  // Sample-tick prescaler
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_r <= '0;
    end else if (tick_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  assign tick_s = (pre_r == PRE_MAX);

  genvar g;
  generate
    for (g = 0; g < N_SENSORES; g++) begin : gen_canal
      antirrebote_canal #(.DEBOUNCE(DEBOUNCE)) u_canal (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick_s),
        .raw      (raw_r[g]),
        .filtrado (filtrado[g])
      );
    end
  endgenerate

  assign hay_linea_s = |filtrado;

  // Lowest and highest active channel; later loop iterations win
  always_comb begin
    min_idx_s = '0;
    max_idx_s = '0;
    for (int i = N_SENSORES - 1; i >= 0; i--) begin
      if (filtrado[i]) begin
        min_idx_s = POS_W'(i);
      end else begin
        min_idx_s = min_idx_s;
      end
    end
    for (int i = 0; i < N_SENSORES; i++) begin
      if (filtrado[i]) begin
        max_idx_s = POS_W'(i);
      end else begin
        max_idx_s = max_idx_s;
      end
    end
    pos_calc_s = min_idx_s + max_idx_s;
  end

  // Next state and loss-hold counter
  always_comb begin
    state_next_s = state_r;
    hold_next_s  = hold_r;
    case (state_r)
      SIN_LINEA: begin
        if (hay_linea_s) begin
          state_next_s = EN_LINEA;
        end else begin
          state_next_s = SIN_LINEA;
        end
      end
      EN_LINEA: begin
        if (!hay_linea_s) begin
          state_next_s = PERDIDA;
          hold_next_s  = '0;
        end else begin
          state_next_s = EN_LINEA;
        end
      end
      PERDIDA: begin
        if (hay_linea_s) begin
          state_next_s = EN_LINEA;
          hold_next_s  = '0;
        end else if (tick_s) begin
          if (hold_r == HOLD_MAX) begin
            state_next_s = SIN_LINEA;
            hold_next_s  = '0;
          end else begin
            hold_next_s = hold_r + HOLD_W'(1);
          end
        end else begin
          hold_next_s = hold_r;
        end
      end
      default: begin
        state_next_s = SIN_LINEA;
        hold_next_s  = '0;
      end
    endcase
  end

  // posicion only tracks the line while it is (about to be) present
  assign pos_next_s  = (state_next_s == EN_LINEA) ? pos_calc_s : posicion;
  assign se_pierde_s = (state_r == EN_LINEA) && (state_next_s == PERDIDA);

  // State, position, Moore flags, loss side and change strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= SIN_LINEA;
      hold_r   <= '0;
      posicion <= POS_CENTRO;
      enLinea  <= 1'b0;
      perdida  <= 1'b0;
      lado     <= LADO_IZQ;
      cambio   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      hold_r   <= hold_next_s;
      posicion <= pos_next_s;
      enLinea  <= (state_next_s == EN_LINEA);
      perdida  <= (state_next_s == PERDIDA);
      cambio   <= (state_next_s != state_r) || (pos_next_s != posicion);
      if (se_pierde_s) begin
        // A centered last position counts as a loss to the left
        lado <= (posicion > POS_CENTRO) ? LADO_DER : LADO_IZQ;
      end
    end
  end

`ifdef FILTRO_LINEA_CONTADOR_EN
  // Saturating count of EN_LINEA -> PERDIDA transitions
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perdidasTotales <= 16'h0000;
    end else if (se_pierde_s && (perdidasTotales != 16'hFFFF)) begin
      perdidasTotales <= perdidasTotales + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_filtro_linea_infrarojo.sv
// -----------------------------------------------------------------------------
// tb_filtro_linea_infrarojo
// Self-checking bench for filtro_linea_infrarojo with SAMPLE_DIV=4,
// DEBOUNCE=3, LOST_HOLD=5, N=4. Each table row drives a pattern for a number
// of sample ticks; expected outputs are queued on drive and compared at the
// end of the row, including the number of cambio pulses seen in the row.
// -----------------------------------------------------------------------------
module tb_filtro_linea_infrarojo;

  logic       clock;
  logic       reset;
  logic [3:0] hayNegro;
  logic [3:0] filtrado;
  logic [2:0] posicion;
  logic       enLinea;
  logic       perdida;
  logic       lado;
  logic       cambio;
`ifdef FILTRO_LINEA_CONTADOR_EN
  logic [15:0] perdidasTotales;
`endif

  int compared   = 0;
  int mismatched = 0;

  filtro_linea_infrarojo #(
    .N_SENSORES (4),
    .SAMPLE_DIV (4),
    .DEBOUNCE   (3),
    .LOST_HOLD  (5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .hayNegro (hayNegro),
    .filtrado (filtrado),
    .posicion (posicion),
    .enLinea  (enLinea),
    .perdida  (perdida),
    .lado     (lado),
    .cambio   (cambio)
`ifdef FILTRO_LINEA_CONTADOR_EN
    ,.perdidasTotales (perdidasTotales)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] pat;
    int         ticks;
    logic [3:0] f;
    logic [2:0] pos;
    logic       en;
    logic       perd;
    logic       lado;
    int         pulses;
  } vec_t;

  vec_t vecs[19];
  vec_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    int   pulses;

    //          pat     tk f        pos   en    perd  lado  pulses
    vecs[0]  = '{4'b1111, 3, 4'b1111, 3'd3, 1'b1, 1'b0, 1'b0, 1}; // line from reset pattern
    vecs[1]  = '{4'b0000, 3, 4'b0000, 3'd3, 1'b0, 1'b1, 1'b0, 1}; // centered loss -> left
    vecs[2]  = '{4'b0000, 4, 4'b0000, 3'd3, 1'b0, 1'b1, 1'b0, 0}; // still holding
    vecs[3]  = '{4'b0000, 1, 4'b0000, 3'd3, 1'b0, 1'b0, 1'b0, 1}; // 5th tick -> SIN_LINEA
    vecs[4]  = '{4'b0100, 2, 4'b0000, 3'd3, 1'b0, 1'b0, 1'b0, 0}; // 2 ticks: no flip
    vecs[5]  = '{4'b0000, 1, 4'b0000, 3'd3, 1'b0, 1'b0, 1'b0, 0}; // agreeing tick restarts
    vecs[6]  = '{4'b0100, 2, 4'b0000, 3'd3, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{4'b0100, 1, 4'b0100, 3'd4, 1'b1, 1'b0, 1'b0, 1}; // 3rd consecutive tick
    vecs[8]  = '{4'b0011, 3, 4'b0011, 3'd1, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'b1100, 3, 4'b1100, 3'd5, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{4'b1001, 3, 4'b1001, 3'd3, 1'b1, 1'b0, 1'b0, 1}; // non-contiguous
    vecs[11] = '{4'b1000, 3, 4'b1000, 3'd6, 1'b1, 1'b0, 1'b0, 1};
    vecs[12] = '{4'b0000, 3, 4'b0000, 3'd6, 1'b0, 1'b1, 1'b1, 1}; // loss to right
    vecs[13] = '{4'b0010, 3, 4'b0010, 3'd2, 1'b1, 1'b0, 1'b1, 1}; // recovery from PERDIDA
    vecs[14] = '{4'b0000, 3, 4'b0000, 3'd2, 1'b0, 1'b1, 1'b0, 1}; // loss to left
    vecs[15] = '{4'b0000, 4, 4'b0000, 3'd2, 1'b0, 1'b1, 1'b0, 0}; // full hold needed again
    vecs[16] = '{4'b0000, 1, 4'b0000, 3'd2, 1'b0, 1'b0, 1'b0, 1};
    vecs[17] = '{4'b1000, 3, 4'b1000, 3'd6, 1'b1, 1'b0, 1'b0, 1}; // pos+state: one pulse
    vecs[18] = '{4'b0000, 3, 4'b0000, 3'd6, 1'b0, 1'b1, 1'b1, 1};

    // Reset held with all sensors black
    reset    = 1'b0;
    hayNegro = 4'b1111;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_filtrado", int'(filtrado), 0);
    chk("rst_posicion", int'(posicion), 3);
    chk("rst_enLinea",  int'(enLinea),  0);
    chk("rst_perdida",  int'(perdida),  0);
    chk("rst_cambio",   int'(cambio),   0);
    reset = 1'b1;

    // Align so each row starts two clocks before a sample tick
    repeat (2) begin
      @(posedge clock);
      #1;
    end

    for (int r = 0; r < 19; r++) begin
      hayNegro = vecs[r].pat;
      exp_q.push_back(vecs[r]);
      pulses = 0;
      for (int c = 0; c < vecs[r].ticks * 4; c++) begin
        @(posedge clock);
        #1;
        if (cambio) pulses++;
      end
      e = exp_q.pop_front();
      chk($sformatf("row%0d_filtrado", r), int'(filtrado), int'(e.f));
      chk($sformatf("row%0d_posicion", r), int'(posicion), int'(e.pos));
      chk($sformatf("row%0d_enLinea",  r), int'(enLinea),  int'(e.en));
      chk($sformatf("row%0d_perdida",  r), int'(perdida),  int'(e.perd));
      chk($sformatf("row%0d_lado",     r), int'(lado),     int'(e.lado));
      chk($sformatf("row%0d_cambio_pulses", r), pulses, e.pulses);
    end

`ifdef FILTRO_LINEA_CONTADOR_EN
    chk("perdidasTotales_count", int'(perdidasTotales), 4);
`endif

    // Asynchronous reset between clock edges while in PERDIDA
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_filtrado", int'(filtrado), 0);
    chk("arst_posicion", int'(posicion), 3);
    chk("arst_enLinea",  int'(enLinea),  0);
    chk("arst_perdida",  int'(perdida),  0);
    chk("arst_lado",     int'(lado),     0);
    chk("arst_cambio",   int'(cambio),   0);
`ifdef FILTRO_LINEA_CONTADOR_EN
    chk("arst_perdidasTotales", int'(perdidasTotales), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
